// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit path.
// Line states are {dp,dm}.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    // bit 0 goes on the wire first
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI line-state register: a 0 toggles J/K, a 1 holds; se0 forces SE0.
// With neither en nor se0 the line parks at J, so every packet starts from J.
module usb_nrzi_enc
    import usb_pkg::*;
(
    input  logic clk,
    input  logic rst_b,
    input  logic en,
    input  logic bit_in,
    input  logic se0,
    output logic dp,
    output logic dm
);

    logic [1:0] line_q;
    logic [1:0] line_d;

    always_comb begin
        line_d = J;
        if (se0) begin
            line_d = SE0;
        end else if (en) begin
            line_d = bit_in ? line_q : ((line_q == J) ? K : J);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            line_q <= J;
        end else begin
            line_q <= line_d;
        end
    end

    assign dp = line_q[1];
    assign dm = line_q[0];

endmodule

// File: rtl/usb_tx_serializer.sv
// USB packet transmitter: SYNC, bit-stuffed body, EOP.
// The line is registered in usb_nrzi_enc, so it shows each bit one cycle after the FSM emits it.
module usb_tx_serializer
    import usb_pkg::*;
#(
    parameter int MAX_BITS  = 99,
    parameter int STUFF_RUN = 6,
    parameter int LEN_W     = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [MAX_BITS-1:0] pkt_in,
    input  logic [LEN_W-1:0]    pkt_len,
    input  logic                pkt_in_avail,
    output logic                encoder_ready,
    output logic                re,
    output logic                dp_w,
    output logic                dm_w,
    output logic                pkt_done
);

    localparam int                ONES_W  = $clog2(STUFF_RUN + 1);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_BITS);
    localparam logic [ONES_W-1:0] RUN_LEN = ONES_W'(STUFF_RUN);

    tx_state_t           state;
    tx_state_t           state_d;
    logic [MAX_BITS-1:0] body_q;
    logic [LEN_W-1:0]    left_q;
    logic [ONES_W-1:0]   ones_q;
    logic [ONES_W-1:0]   ones_inc;
    logic [2:0]          phase_q;
    logic                done_q;
    logic                take;
    logic                tx_en;
    logic                tx_bit;
    logic                run_full;
    logic                line_se0;

    assign ones_inc = ones_q + 1'b1;
    assign run_full = tx_en && tx_bit && (ones_inc == RUN_LEN);

    always_comb begin
        state_d       = state;
        take          = 1'b0;
        tx_en         = 1'b0;
        tx_bit        = 1'b1;
        line_se0      = 1'b0;
        encoder_ready = 1'b0;
        re            = 1'b1;
        case (state)
            IDLE: begin
                encoder_ready = 1'b1;
                re            = 1'b0;
                if (pkt_in_avail) begin
                    take    = 1'b1;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                tx_en  = 1'b1;
                tx_bit = SYNC_PATTERN[phase_q];
                if (phase_q == 3'd7) begin
                    if (run_full)                state_d = STUFF;
                    else if (left_q == '0)       state_d = EOP_SE0;
                    else                         state_d = DATA;
                end
            end
            DATA: begin
                tx_en  = 1'b1;
                tx_bit = body_q[0];
                if (run_full)                    state_d = STUFF;
                else if (left_q == LEN_W'(1))    state_d = EOP_SE0;
            end
            STUFF: begin
                tx_en   = 1'b1;
                tx_bit  = 1'b0;
                state_d = (left_q == '0) ? EOP_SE0 : DATA;
            end
            EOP_SE0: begin
                line_se0 = 1'b1;
                if (phase_q == 3'd1) state_d = EOP_J;
            end
            EOP_J: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Body advances only in DATA; STUFF inserts a 0 without consuming a body bit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            body_q  <= '0;
            left_q  <= '0;
            ones_q  <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == EOP_J);
            if (state == SYNC || state == EOP_SE0) begin
                phase_q <= phase_q + 1'b1;
            end else begin
                phase_q <= '0;
            end
            if (take) begin
                body_q <= pkt_in;
                left_q <= (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
                ones_q <= '0;
            end else if (tx_en) begin
                ones_q <= tx_bit ? ones_inc : '0;
                if (state == DATA) begin
                    body_q <= body_q >> 1;
                    left_q <= left_q - 1'b1;
                end
            end
        end
    end

    assign pkt_done = done_q;

    usb_nrzi_enc u_nrzi (
        .clk    (clk),
        .rst_b  (rst_b),
        .en     (tx_en),
        .bit_in (tx_bit),
        .se0    (line_se0),
        .dp     (dp_w),
        .dm     (dm_w)
    );

endmodule

// File: doc/usb_tx_serializer.md
USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 Parameter MAX_BITS, default 99: widest packet body accepted, in bits.
REQ-002 Parameter STUFF_RUN, default 6: consecutive ones on the line that force a stuffed 0.
REQ-003 Parameter LEN_W, default $clog2(MAX_BITS+1): width of pkt_len.
REQ-004 Port clk, input, 1: bit-rate clock, one line bit per cycle.
REQ-005 Port rst_b, input, 1: asynchronous active-low reset.
REQ-006 Port pkt_in, input, MAX_BITS: packet body, bit 0 transmitted first.
REQ-007 Port pkt_len, input, LEN_W: number of valid body bits in pkt_in.
REQ-008 Port pkt_in_avail, input, 1: packet offer, sampled only while encoder_ready=1.
REQ-009 Port encoder_ready, output, 1: block is idle and accepts a packet.
REQ-010 Port re, output, 1: bus drive enable, high while this block owns the line.
REQ-011 Port dp_w, output, 1: D+ line value.
REQ-012 Port dm_w, output, 1: D- line value.
REQ-013 Port pkt_done, output, 1: one-cycle pulse after EOP completes.

Function
REQ-014 States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
REQ-015 In IDLE: encoder_ready=1, re=0, line held J (dp_w=1, dm_w=0).
REQ-016 Accept rule: IDLE with pkt_in_avail=1 at a clock edge latches pkt_in and pkt_len into internal registers, clears the ones counter, and enters SYNC; encoder_ready drops in the next cycle.
REQ-017 pkt_in_avail outside IDLE is ignored; no queuing.
REQ-018 pkt_len > MAX_BITS is clamped to MAX_BITS.
REQ-019 SYNC emits the 8 bits 0,0,0,0,0,0,0,1 in order, one per cycle.
REQ-020 DATA emits latched body bits 0..pkt_len-1 in order.
REQ-021 pkt_len=0: SYNC goes directly to EOP_SE0.
REQ-022 Ones counter:
  - increments on each emitted 1, including the SYNC bits;
  - clears on any emitted 0, including stuffed bits.
REQ-023 When the counter reaches STUFF_RUN, the next cycle is STUFF. STUFF emits a 0 without advancing the body index, then resumes DATA, or goes to EOP_SE0 if the body is exhausted.
REQ-024 NRZI encoding: a 0 toggles the line state and a 1 holds it. The NRZI state starts at J on entry to SYNC. J = (dp_w=1, dm_w=0); K = (0, 1).
REQ-025 EOP_SE0 lasts 2 cycles with dp_w=dm_w=0 and is not NRZI encoded.
REQ-026 EOP_J lasts 1 cycle with the line at J, then the block returns to IDLE with pkt_done=1 for that one cycle.
REQ-027 re=1 from the first SYNC cycle through the EOP_J cycle inclusive; re=0 otherwise.
REQ-028 Total busy cycles = 8 + pkt_len + stuffed_bits + 3.

Reset
REQ-029 rst_b low forces, asynchronously: IDLE state, encoder_ready=1, re=0, dp_w=1, dm_w=0, pkt_done=0, and all counters and registers cleared.
REQ-030 Reset asserted mid-packet aborts the packet immediately: no EOP is sent and no pkt_done pulse is produced.

Structure
REQ-031 A shared package usb_pkg SHALL hold:
  - the state enum type;
  - SYNC_PATTERN = 8'b1000_0000 (bit 0 sent first);
  - line-state constants J, K and SE0 as {dp,dm} 2-bit values.
REQ-032 NRZI line-state tracking SHALL be one sub-module, usb_nrzi_enc, with ports clk, rst_b, en, bit_in, se0, dp, dm. The FSM, body shift register, length counter and ones counter stay in usb_tx_serializer.

Verification
REQ-033 pkt_len=0 -> line shows J K J K J K J K (SYNC, NRZI-encoded), then K (the final SYNC 1 holds), then SE0, SE0, J; pkt_done pulses once; 11 busy cycles.
REQ-034 pkt_len=8, pkt_in=8'hFF -> exactly one stuffed 0 inserted after the 5th body bit (the SYNC 1 plus 5 body ones reach 6); 20 busy cycles.
REQ-035 pkt_len=16, pkt_in=16'h0000 -> no stuffed bits, line toggles every data cycle, 27 busy cycles.
REQ-036 pkt_in_avail held high during a busy period -> only one packet sent; a second packet starts the cycle after pkt_done when avail is still high.
REQ-037 rst_b pulsed low in the 5th DATA cycle -> dp_w=1, dm_w=0, re=0 and encoder_ready=1 asynchronously; no pkt_done pulse.
REQ-038 MAX_BITS=32, STUFF_RUN=3, pkt_len=40, pkt_in=all ones -> pkt_len clamped to 32 and a stuffed bit inserted after every run of 3 ones.
